// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, taken branches, mul/div occupancy of EX and
// halt drain. Control outputs are combinational from state plus inputs;
// state, the shared down-counter and the saturating statistics are registered.
module pipeline_hazard_controller #(
  parameter int MULDIV_CYCLES = 4,  // 2..16
  parameter int DRAIN_CYCLES  = 3   // 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  id_op1,
  input  logic [3:0]  id_op2,
  input  logic        id_uses_op2,
  input  logic        id_halt,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_write_reg,
  input  logic        ex_branch_taken,
  input  logic        ex_muldiv,
  output logic        pc_stop,
  output logic        pc_mux,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_hold,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {RUN, MULDIV, DRAIN, HALTED} state_t;

  // Reload values for the shared counter; both fit in 4 bits for legal params.
  localparam logic [3:0] MD_LOAD    = 4'(MULDIV_CYCLES - 2);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       stall_inc, flush_inc;
  logic       load_use;

  // Register 0 is deliberately not exempt from the hazard compare.
  assign load_use = ex_mem_read &&
                    ((ex_write_reg == id_op1) ||
                     (id_uses_op2 && (ex_write_reg == id_op2)));

  // Next-state, counter and control-output decode; reset forces controls low.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_stop      = 1'b0;
    pc_mux       = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX.
            pc_mux      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (ex_muldiv) begin
            pc_stop      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_flush = 1'b1;
            stall_inc    = 1'b1;
            cnt_nxt      = MD_LOAD;
            state_nxt    = MULDIV;
          end else if (load_use) begin
            // One bubble; the load moves on to MEM so no state is needed.
            pc_stop     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else if (id_halt) begin
            // Halt advances into ID/EX; nothing behind it is fetched.
            pc_stop     = 1'b1;
            if_id_flush = 1'b1;
            cnt_nxt     = DRAIN_LOAD;
            state_nxt   = DRAIN;
          end
        end
        MULDIV: begin
          if (cnt != 4'd0) begin
            pc_stop      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_flush = 1'b1;
            stall_inc    = 1'b1;
            cnt_nxt      = cnt - 4'd1;
          end else begin
            // Release cycle: all controls low, back to normal issue.
            state_nxt = RUN;
          end
        end
        DRAIN: begin
          pc_stop     = 1'b1;
          if_id_flush = 1'b1;
          if (cnt == 4'd0) state_nxt = HALTED;
          else             cnt_nxt   = cnt - 4'd1;
        end
        HALTED: begin
          pc_stop     = 1'b1;
          if_id_flush = 1'b1;
          halted      = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, counter and saturating statistics registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if (flush_inc && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage 16-bit pipeline. It sits between the decode/execute stage signals and the program counter and pipeline buffers. It drives PC stop and select, and the hold/flush controls of the IF/ID, ID/EX and EX/MEM buffers. It resolves load-use hazards, taken branches/jumps, multi-cycle multiply/divide occupancy of EX, and halt drain, and keeps saturating stall and flush statistics.

## Interface
Parameters:
- MULDIV_CYCLES, 4: total cycles a mul/div occupies EX; legal values 2..16.
- DRAIN_CYCLES, 3: cycles for a halt to travel from ID to completion of WB; legal values 1..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_op1  in  4  register field [11:8] of the instruction in ID.
- id_op2  in  4  register field [7:4] of the instruction in ID.
- id_uses_op2  in  1  ID instruction reads id_op2.
- id_halt  in  1  ID holds a halt opcode.
- ex_mem_read  in  1  EX instruction is a load.
- ex_write_reg  in  4  destination register of the EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- ex_muldiv  in  1  EX holds a multiply/divide.
- pc_stop  out  1  freeze the PC.
- pc_mux  out  1  select the branch target into the PC (IF mux select).
- if_id_hold, if_id_flush  out  1 each  IF/ID buffer controls.
- id_ex_hold, id_ex_flush  out  1 each  ID/EX buffer controls.
- ex_mem_flush  out  1  insert a bubble into EX/MEM.
- halted  out  1  the processor has stopped.
- stall_count  out  16  saturating count of load-use plus mul/div stall cycles.
- flush_count  out  16  saturating count of taken branches.

## Operation
- States: RUN, MULDIV, DRAIN, HALTED. There is one shared down-counter cnt, 4 bits wide.
- Reset: the state goes to RUN and cnt, stall_count and flush_count go to 0. While reset is high, all control outputs are forced to 0. Reset has priority over every event, including reset in MULDIV, DRAIN or HALTED.
- Outputs are combinational from state plus inputs. Any output not listed for a case is 0.
- RUN uses these priorities, first match wins:
  1. Branch: ex_branch_taken. Assert pc_mux, if_id_flush and id_ex_flush. Increment flush_count. Stay in RUN.
  2. Mul/div: ex_muldiv. Assert pc_stop, if_id_hold, id_ex_hold and ex_mem_flush. Load cnt with MULDIV_CYCLES-2. Go to MULDIV. Increment stall_count.
  3. Load-use: ex_mem_read and (ex_write_reg==id_op1 or (id_uses_op2 and ex_write_reg==id_op2)). Assert pc_stop, if_id_hold and id_ex_flush. Increment stall_count. Stay in RUN. Register 0 is not exempt.
  4. Halt: id_halt. Assert pc_stop and if_id_flush; the halt itself advances into ID/EX. Load cnt with DRAIN_CYCLES-1. Go to DRAIN.
  5. Otherwise, all outputs are 0.
- MULDIV:
  - If cnt != 0: assert pc_stop, if_id_hold, id_ex_hold and ex_mem_flush; decrement cnt; increment stall_count.
  - If cnt == 0: all outputs are 0 (release cycle) and the state goes to RUN. ex_muldiv is ignored in this state.
- DRAIN: assert pc_stop and if_id_flush. If cnt == 0, go to HALTED; otherwise decrement cnt. All other inputs are ignored.
- HALTED: assert pc_stop, if_id_flush and halted. Only reset exits this state.
- Counters increment by 1 per qualifying cycle and saturate at 16'hFFFF (no wrap).

## Timing
- Latency from input to control output is zero cycles (combinational). State and counters take effect on the next rising edge.
- A load-use hazard costs exactly 1 stall cycle. The load moves to MEM, so the hazard clears with no state.
- A mul/div costs exactly MULDIV_CYCLES-1 stall cycles, followed by 1 release cycle.
- A taken branch costs 1 cycle and squashes 2 wrong-path instructions.
- After id_halt is accepted in RUN, halted rises DRAIN_CYCLES+1 edges later.
- Simultaneous events:
  - A branch with halt or load-use: the branch wins and the halt is squashed.
  - A mul/div with halt or load-use: the mul/div wins and the ID instruction is held.
  - A load-use with halt: the stall comes first, and the halt is taken on the following cycle.

## Test plan
- Reset: hold reset 2 cycles with all inputs at 1, then release with inputs at 0. Required: all outputs 0, stall_count=flush_count=0, and the state is RUN.
- Load-use: ex_mem_read=1, ex_write_reg=5, id_op2=5, id_uses_op2=1 for 1 cycle. Required: pc_stop=if_id_hold=id_ex_flush=1 for 1 cycle, then stall_count=1. Repeat with id_uses_op2=0 and id_op1=3. Required: no stall.
- Mul/div, MULDIV_CYCLES=4: ex_muldiv=1 held for 4 cycles. Required: pc_stop, holds and ex_mem_flush high for exactly 3 cycles and low on the 4th, then stall_count=3.
- Branch plus halt: ex_branch_taken=1 and id_halt=1 in the same cycle. Required: pc_mux=if_id_flush=id_ex_flush=1, the state stays RUN, flush_count=1 and halted never rises.
- Halt, DRAIN_CYCLES=3: id_halt for 1 cycle. Required: pc_stop stays high from that cycle on, halted=1 exactly 4 edges later, and it persists until reset. Asserting reset during DRAIN instead returns the state to RUN with halted=0.
- Saturation: force 70000 load-use cycles. Required: stall_count=16'hFFFF and it does not wrap.
